// File: rtl/hazard_pkg.sv
// hazard_move shared types and screen geometry.
// Fixed-point X uses FRAC_BITS fractional bits.
package hazard_pkg;
  localparam int SCREEN_W  = 640;
  localparam int FRAC_BITS = 4;
  localparam int POS_W     = 15;
  localparam int XW        = POS_W - FRAC_BITS;
  localparam int WRAP_FX   = SCREEN_W << FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    HIT,
    RESPAWN
  } hazard_state_t;
endpackage

// File: rtl/hazard_move_if.sv
// Frame/collision inputs and sprite coordinate outputs.
// master drives the controls, slave is the hazard.
interface hazard_move_if
  import hazard_pkg::*;
  ();
  logic          startOfFrame;
  logic          enable;
  logic          collision;
  logic [XW-1:0] ObjectStartX;
  logic [XW-1:0] ObjectStartY;
  logic          visible;
  logic          hit;

  modport master (
    output startOfFrame, enable, collision,
    input  ObjectStartX, ObjectStartY, visible, hit
  );

  modport slave (
    input  startOfFrame, enable, collision,
    output ObjectStartX, ObjectStartY, visible, hit
  );
endinterface

// File: rtl/pos_wrap_step.sv
// One fixed-point X step with wrap across the screen.
// Fraction bits pass through the wrap untouched.
module pos_wrap_step
  import hazard_pkg::*;
(
  input  logic [POS_W-1:0]  i_pos_fx,
  input  logic signed [15:0] i_speed,
  output logic [POS_W-1:0]  o_pos_fx
);
  localparam logic signed [15:0] W = 16'(WRAP_FX);

  logic signed [15:0] w_n;
  logic signed [15:0] w_r;

  always_comb begin
    w_n = $signed({1'b0, i_pos_fx}) + i_speed;
    w_r = w_n;
    if (w_n < 0)
      w_r = w_n + W;
    else if (w_n >= W)
      w_r = w_n - W;
    o_pos_fx = POS_W'(w_r);
  end
endmodule

// File: rtl/hazard_move.sv
// Lane hazard position controller with hit/respawn FSM.
// Optional blink during HIT: define HAZARD_BLINK_EN.
module hazard_move
  import hazard_pkg::*;
#(
  parameter int INIT_X     = 100,
  parameter int LANE_Y     = 200,
  parameter int SPEED_X    = 32,
  parameter int HIT_FRAMES = 30
) (
  input logic           CLK,
  input logic           RESET,
  hazard_move_if.slave  bus
);
  localparam logic [POS_W-1:0] INIT_FX =
    POS_W'(INIT_X << FRAC_BITS);
  localparam logic [7:0] CNT_LOAD = 8'(HIT_FRAMES - 1);
  localparam logic signed [15:0] SPD = 16'(SPEED_X);

  hazard_state_t    r_state;
  hazard_state_t    w_state_n;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_n;
  logic [POS_W-1:0] w_step;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_n;
  logic             r_pend;
  logic             w_col;
  logic             r_vis;
  logic             w_vis_n;
  logic             r_hit;
  logic             w_hit_n;
`ifdef HAZARD_BLINK_EN
  logic [1:0]       r_blk;
  logic [1:0]       w_blk_n;
  logic             r_bvis;
  logic             w_bvis_n;
`endif

  pos_wrap_step u_step (
    .i_pos_fx (r_pos),
    .i_speed  (SPD),
    .o_pos_fx (w_step)
  );

  always_comb begin
    w_col     = r_pend | bus.collision;
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_cnt_n   = r_cnt;
`ifdef HAZARD_BLINK_EN
    w_blk_n   = r_blk;
    w_bvis_n  = r_bvis;
`endif
    if (!bus.enable) begin
      w_state_n = IDLE;
      w_pos_n   = INIT_FX;
    end else if (bus.startOfFrame) begin
      unique case (r_state)
        IDLE: w_state_n = MOVE;
        MOVE: begin
          if (w_col) begin
            w_state_n = HIT;
            w_cnt_n   = CNT_LOAD;
`ifdef HAZARD_BLINK_EN
            w_blk_n   = 2'd0;
            w_bvis_n  = 1'b1;
`endif
          end else begin
            w_pos_n = w_step;
          end
        end
        HIT: begin
          if (r_cnt == 8'd0) begin
            w_state_n = RESPAWN;
            w_pos_n   = INIT_FX;
          end else begin
            w_cnt_n = r_cnt - 8'd1;
`ifdef HAZARD_BLINK_EN
            // visibility flips each time the 2-bit count wraps
            w_blk_n = r_blk + 2'd1;
            if (r_blk == 2'd3)
              w_bvis_n = ~r_bvis;
`endif
          end
        end
        RESPAWN: w_state_n = MOVE;
      endcase
    end
    w_hit_n = (w_state_n == HIT);
    w_vis_n = (w_state_n == MOVE);
`ifdef HAZARD_BLINK_EN
    if (w_state_n == HIT)
      w_vis_n = w_bvis_n;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_pos   <= INIT_FX;
      r_cnt   <= 8'd0;
      r_pend  <= 1'b0;
      r_vis   <= 1'b0;
      r_hit   <= 1'b0;
`ifdef HAZARD_BLINK_EN
      r_blk   <= 2'd0;
      r_bvis  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_pos   <= w_pos_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= bus.startOfFrame ? 1'b0 : w_col;
      r_vis   <= w_vis_n;
      r_hit   <= w_hit_n;
`ifdef HAZARD_BLINK_EN
      r_blk   <= w_blk_n;
      r_bvis  <= w_bvis_n;
`endif
    end
  end

  assign bus.ObjectStartX = r_pos[POS_W-1:FRAC_BITS];
  assign bus.ObjectStartY = XW'(LANE_Y);
  assign bus.visible      = r_vis;
  assign bus.hit          = r_hit;
endmodule

// File: tb/tb_hazard_move.sv
// Randomized scoreboard bench for hazard_move.
// Two instances (right-wrap and left-wrap) share stimulus.
module tb_hazard_move;
  localparam int W16 = 640 * 16;
  localparam int NCYC = 4000;

  localparam int A_INIT = 630, A_LANE = 200, A_SPD = 157, A_HF = 3;
  localparam int B_INIT = 5,   B_LANE = 321, B_SPD = -211, B_HF = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_move_if ifa ();
  hazard_move_if ifb ();

  hazard_move #(
    .INIT_X(A_INIT), .LANE_Y(A_LANE),
    .SPEED_X(A_SPD), .HIT_FRAMES(A_HF)
  ) dut_a (.CLK(clk), .RESET(rst), .bus(ifa.slave));

  hazard_move #(
    .INIT_X(B_INIT), .LANE_Y(B_LANE),
    .SPEED_X(B_SPD), .HIT_FRAMES(B_HF)
  ) dut_b (.CLK(clk), .RESET(rst), .bus(ifb.slave));

  typedef struct {
    int due;
    int x[2];
    int y[2];
    int vis[2];
    int hit[2];
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 move, 2 hit, 3 respawn
  int m_mode[2], m_pos[2], m_pend[2], m_hitfr[2];
  int p_init[2], p_lane[2], p_spd[2], p_hf[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_cycle(input int k, input bit r, input bit en,
                             input bit sof, input bit col);
    int c;
    if (r) begin
      m_mode[k] = 0; m_pos[k] = p_init[k] * 16;
      m_pend[k] = 0; m_hitfr[k] = 0;
      return;
    end
    c = m_pend[k] | int'(col);
    m_pend[k] = sof ? 0 : c;
    if (!en) begin
      m_mode[k] = 0; m_pos[k] = p_init[k] * 16;
    end else if (sof) begin
      case (m_mode[k])
        0: m_mode[k] = 1;
        1: if (c != 0) begin
             m_mode[k] = 2; m_hitfr[k] = 0;
           end else begin
             m_pos[k] = ((m_pos[k] + p_spd[k]) % W16 + W16) % W16;
           end
        2: if (m_hitfr[k] == p_hf[k] - 1) begin
             m_mode[k] = 3; m_pos[k] = p_init[k] * 16;
           end else m_hitfr[k]++;
        default: m_mode[k] = 1;
      endcase
    end
  endtask

  function automatic int exp_vis(input int k);
    if (m_mode[k] == 1) return 1;
`ifdef HAZARD_BLINK_EN
    if (m_mode[k] == 2) return ((m_hitfr[k] / 4) % 2 == 0) ? 1 : 0;
`endif
    return 0;
  endfunction

  task automatic drive_and_push(input bit r, input bit en,
                                input bit sof, input bit col);
    exp_t e;
    rst = r;
    ifa.enable = en; ifb.enable = en;
    ifa.startOfFrame = sof; ifb.startOfFrame = sof;
    ifa.collision = col; ifb.collision = col;
    for (int k = 0; k < 2; k++) begin
      model_cycle(k, r, en, sof, col);
      e.x[k] = m_pos[k] / 16;
      e.y[k] = p_lane[k];
      e.vis[k] = exp_vis(k);
      e.hit[k] = (m_mode[k] == 2) ? 1 : 0;
    end
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, req);
    end
  endtask

  // monitor: pops the expectation due this cycle and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
        n_cmp++; n_bad++;
        $display("FAIL sb_stale cyc=%0d got missed want due", cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("a_x",   int'(ifa.ObjectStartX), e.x[0]);
        chk("a_y",   int'(ifa.ObjectStartY), e.y[0]);
        chk("a_vis", int'(ifa.visible),      e.vis[0]);
        chk("a_hit", int'(ifa.hit),          e.hit[0]);
        chk("b_x",   int'(ifb.ObjectStartX), e.x[1]);
        chk("b_y",   int'(ifb.ObjectStartY), e.y[1]);
        chk("b_vis", int'(ifb.visible),      e.vis[1]);
        chk("b_hit", int'(ifb.hit),          e.hit[1]);
      end
    end
  end

  initial begin
    int flen, fpos;
    bit en, sof, col, r;
    p_init = '{A_INIT, B_INIT}; p_lane = '{A_LANE, B_LANE};
    p_spd  = '{A_SPD, B_SPD};   p_hf   = '{A_HF, B_HF};
    drive_and_push(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_and_push(1'b1, 1'b1, 1'b1, 1'b1);
    en = 1'b1; fpos = 0; flen = 4;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      fpos++;
      sof = (fpos >= flen);
      if (sof) begin
        fpos = 0;
        flen = $urandom_range(3, 7);
      end
      // calm opening stretch so the hazards travel and wrap
      if (i < 300) col = 1'b0;
      else if (sof) col = ($urandom_range(0, 99) < 12);
      else col = ($urandom_range(0, 99) < 3);
      if (!en) en = ($urandom_range(0, 99) < 20);
      else if (i >= 300) en = ($urandom_range(0, 999) >= 8);
      r = (i >= 300) && ($urandom_range(0, 999) < 4);
      drive_and_push(r, en, sof, col);
    end
    @(negedge clk);
    drive_and_push(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() > 1) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_drain got %0d left want <=1", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
